// File: rtl/registro_leds_pwm_pkg.sv
// Shared constants for the LED/PWM peripheral: register addresses and CTRL bit positions.
package registro_leds_pwm_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_BLINK = 2'd1;
  localparam logic [1:0] ADDR_DUTY  = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_INV = 1;

endpackage

// File: rtl/registro_leds_pwm_led_tick_gen.sv
// Prescaler producing a one-cycle tick on each wrap, plus a blink phase that toggles
// every BLINK_TICKS ticks. A clear restarts both from a known phase.
module led_tick_gen #(
  parameter int unsigned PRESC_DIV   = 50000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic blinkPhase
);

  localparam int unsigned PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  logic [PW-1:0] presc_q;
  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;

  assign tick       = (presc_q == PRESC_MAX);
  assign blinkPhase = phase_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      presc_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (blink_cnt_q == BLINK_MAX) begin
          blink_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/registro_leds_pwm.sv
// Memory-mapped LED peripheral: DATA/BLINK/DUTY/CTRL registers with readback,
// per-LED blink, global PWM brightness, enable and inversion on a registered output.
module registro_leds_pwm
  import registro_leds_pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PWM_BITS    = 4,
  parameter int unsigned PRESC_DIV   = 50000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipSelect,
  input  logic             write,
  input  logic             read,
  input  logic [1:0]       address,
  input  logic [WIDTH-1:0] dataWrite,
  output logic [WIDTH-1:0] dataRead,
  output logic [WIDTH-1:0] bus_leds
);

  logic [WIDTH-1:0]    data_q, blink_q, data_read_q, leds_q;
  logic [WIDTH-1:0]    rd_mux, led_on;
  logic [PWM_BITS-1:0] duty_q, pwm_cnt_q;
  logic [1:0]          ctrl_q;
  logic                wr_en, rd_en, ctrl_clear, blink_phase, pwm_on;

  assign wr_en      = chipSelect & write;
  assign rd_en      = chipSelect & read;
  assign ctrl_clear = wr_en && (address == ADDR_CTRL);

  led_tick_gen #(
    .PRESC_DIV  (PRESC_DIV),
    .BLINK_TICKS(BLINK_TICKS)
  ) u_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .clear     (ctrl_clear),
    .tick      (),
    .blinkPhase(blink_phase)
  );

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:  rd_mux = data_q;
      ADDR_BLINK: rd_mux = blink_q;
      ADDR_DUTY:  rd_mux = WIDTH'(duty_q);
      default:    rd_mux = WIDTH'(ctrl_q);
    endcase
  end

  // All-ones duty is forced fully on; a plain compare would drop the top count.
  always_comb begin
    pwm_on = 1'b0;
    if (duty_q == '1) begin
      pwm_on = 1'b1;
    end else if (duty_q != '0) begin
      pwm_on = (pwm_cnt_q < duty_q);
    end
  end

  assign led_on = {WIDTH{ctrl_q[CTRL_EN] & pwm_on}} & data_q
                & (~blink_q | {WIDTH{blink_phase}});

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q      <= '0;
      blink_q     <= '0;
      duty_q      <= '1;
      ctrl_q      <= 2'b01;
      pwm_cnt_q   <= '0;
      data_read_q <= '0;
      leds_q      <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      leds_q    <= led_on ^ {WIDTH{ctrl_q[CTRL_INV]}};
      if (rd_en) begin
        data_read_q <= rd_mux;
      end
      if (wr_en) begin
        case (address)
          ADDR_DATA:  data_q  <= dataWrite;
          ADDR_BLINK: blink_q <= dataWrite;
          ADDR_DUTY:  duty_q  <= dataWrite[PWM_BITS-1:0];
          default:    ctrl_q  <= dataWrite[1:0];
        endcase
      end
    end
  end

  assign dataRead = data_read_q;
  assign bus_leds = leds_q;

endmodule

// File: tb/tb_registro_leds_pwm.sv
// Self-checking bench for registro_leds_pwm: directed scenarios plus random bus traffic
// checked cycle by cycle against an arithmetic reference model.
module tb_registro_leds_pwm;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned PWM_BITS    = 2;
  localparam int unsigned PRESC_DIV   = 4;
  localparam int unsigned BLINK_TICKS = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             chipSelect = 1'b0;
  logic             write = 1'b0;
  logic             read = 1'b0;
  logic [1:0]       address = 2'd0;
  logic [WIDTH-1:0] dataWrite = '0;
  logic [WIDTH-1:0] dataRead, bus_leds;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: registers, cycles since reset (PWM) and since last clear (blink).
  logic [7:0]  m_data, m_blink, exp_leds, exp_rd;
  logic [1:0]  m_ctrl;
  int unsigned m_duty, m_t, m_tc;

  registro_leds_pwm #(
    .WIDTH      (WIDTH),
    .PWM_BITS   (PWM_BITS),
    .PRESC_DIV  (PRESC_DIV),
    .BLINK_TICKS(BLINK_TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chipSelect(chipSelect),
    .write     (write),
    .read      (read),
    .address   (address),
    .dataWrite (dataWrite),
    .dataRead  (dataRead),
    .bus_leds  (bus_leds)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0:    return m_data;
      2'd1:    return m_blink;
      2'd2:    return 8'(m_duty);
      default: return {6'b0, m_ctrl};
    endcase
  endfunction

  // Drive one bus cycle, advance the model across the edge, settle 1 ns past the edge.
  task automatic bus_cycle(input logic rst, input logic cs, input logic wr, input logic rd,
                           input logic [1:0] a, input logic [7:0] d);
    int unsigned pwm, full;
    logic phase, pwm_on, on;
    reset = rst; chipSelect = cs; write = wr; read = rd; address = a; dataWrite = d;
    @(posedge clk);
    if (rst) begin
      m_data = 8'h00; m_blink = 8'h00; m_duty = (1 << PWM_BITS) - 1; m_ctrl = 2'b01;
      m_t = 0; m_tc = 0; exp_leds = 8'h00; exp_rd = 8'h00;
    end else begin
      pwm   = m_t % (1 << PWM_BITS);
      full  = (1 << PWM_BITS) - 1;
      phase = ((m_tc / (PRESC_DIV * BLINK_TICKS)) % 2) == 0;
      if (m_duty == full) pwm_on = 1'b1;
      else if (m_duty == 0) pwm_on = 1'b0;
      else pwm_on = (pwm < m_duty);
      for (int i = 0; i < 8; i++) begin
        on = m_ctrl[0] && m_data[i] && (m_blink[i] ? phase : 1'b1) && pwm_on;
        exp_leds[i] = on ^ m_ctrl[1];
      end
      if (cs && rd) exp_rd = model_reg(a);
      m_t++;
      m_tc++;
      if (cs && wr) begin
        case (a)
          2'd0: m_data = d;
          2'd1: m_blink = d;
          2'd2: m_duty = d % (1 << PWM_BITS);
          default: begin m_ctrl = d[1:0]; m_tc = 0; end
        endcase
      end
    end
    #1;
  endtask

  task automatic do_reset();
    bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (bus_leds !== 8'h00) begin
      n_err++; $display("FAIL reset_leds got=%h exp=00", bus_leds);
    end
    n_vec++;
    if (dataRead !== 8'h00) begin
      n_err++; $display("FAIL reset_dataread got=%h exp=00", dataRead);
    end
  endtask

  task automatic test_read_reset();
    logic [7:0] want [4];
    want[0] = 8'h00; want[1] = 8'h00; want[2] = 8'h03; want[3] = 8'h01;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      bus_cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'(a), 8'h00);
      n_vec++;
      if (dataRead !== want[a] || dataRead !== exp_rd) begin
        n_err++; $display("FAIL read_reset addr=%0d got=%h exp=%h", a, dataRead, want[a]);
      end
    end
  endtask

  task automatic test_data_write();
    do_reset();
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'hA5);
    n_vec++;
    if (bus_leds !== 8'h00) begin
      n_err++; $display("FAIL data_lag1 got=%h exp=00", bus_leds);
    end
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    n_vec++;
    if (bus_leds !== 8'hA5) begin
      n_err++; $display("FAIL data_lag2 got=%h exp=a5", bus_leds);
    end
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
    n_vec++;
    if (dataRead !== 8'hA5) begin
      n_err++; $display("FAIL data_readback got=%h exp=a5", dataRead);
    end
  endtask

  task automatic test_blink();
    logic [7:0] want;
    do_reset();
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'hFF);
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'h0F);
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 8'h01);
    for (int i = 1; i <= 32; i++) begin
      bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      want = (((i - 1) / 8) % 2 == 0) ? 8'hFF : 8'hF0;
      n_vec++;
      if (bus_leds !== want || bus_leds !== exp_leds) begin
        n_err++; $display("FAIL blink cyc=%0d got=%h exp=%h", i, bus_leds, want);
      end
    end
  endtask

  task automatic test_pwm();
    int n_on;
    do_reset();
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'hFF);
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'h01);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    n_on = 0;
    for (int i = 0; i < 16; i++) begin
      bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      if (bus_leds === 8'hFF) n_on++;
      n_vec++;
      if (bus_leds !== exp_leds || (bus_leds !== 8'hFF && bus_leds !== 8'h00)) begin
        n_err++; $display("FAIL pwm_duty1 cyc=%0d got=%h exp=%h", i, bus_leds, exp_leds);
      end
    end
    n_vec++;
    if (n_on != 4) begin
      n_err++; $display("FAIL pwm_duty1_count got=%0d exp=4", n_on);
    end
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'h00);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      n_vec++;
      if (bus_leds !== 8'h00) begin
        n_err++; $display("FAIL pwm_duty0 cyc=%0d got=%h exp=00", i, bus_leds);
      end
    end
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'h03);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      n_vec++;
      if (bus_leds !== 8'hFF) begin
        n_err++; $display("FAIL pwm_duty3 cyc=%0d got=%h exp=ff", i, bus_leds);
      end
    end
  endtask

  task automatic test_ctrl();
    do_reset();
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 8'h02);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    n_vec++;
    if (bus_leds !== 8'hFF) begin
      n_err++; $display("FAIL ctrl_disable_invert got=%h exp=ff", bus_leds);
    end
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h0F);
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 8'h03);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    n_vec++;
    if (bus_leds !== 8'hF0) begin
      n_err++; $display("FAIL ctrl_invert got=%h exp=f0", bus_leds);
    end
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h55);
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 8'h00);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    n_vec++;
    if (bus_leds !== 8'hF0) begin
      n_err++; $display("FAIL ctrl_cs_ignored got=%h exp=f0", bus_leds);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h3C);
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 8'hC3);
    n_vec++;
    if (dataRead !== 8'h3C) begin
      n_err++; $display("FAIL rw_same_old got=%h exp=3c", dataRead);
    end
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
    n_vec++;
    if (dataRead !== 8'hC3) begin
      n_err++; $display("FAIL rw_same_new got=%h exp=c3", dataRead);
    end
  endtask

  task automatic test_reset_write();
    logic [7:0] want [4];
    want[0] = 8'h00; want[1] = 8'h00; want[2] = 8'h03; want[3] = 8'h01;
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'h77);
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h5A);
    bus_cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'hAA);
    n_vec++;
    if (bus_leds !== 8'h00 || dataRead !== 8'h00) begin
      n_err++; $display("FAIL reset_write_out leds=%h rd=%h exp=00/00", bus_leds, dataRead);
    end
    for (int a = 0; a < 4; a++) begin
      bus_cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'(a), 8'h00);
      n_vec++;
      if (dataRead !== want[a]) begin
        n_err++; $display("FAIL reset_write_reg addr=%0d got=%h exp=%h", a, dataRead, want[a]);
      end
    end
  endtask

  task automatic test_random();
    logic rst, cs;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(63) == 0);
      cs  = ($urandom_range(3) != 0);
      bus_cycle(rst, cs, 1'($urandom_range(1)), 1'($urandom_range(1)),
                2'($urandom_range(3)), 8'($urandom));
      n_vec++;
      if (bus_leds !== exp_leds || dataRead !== exp_rd) begin
        n_err++;
        $display("FAIL random cyc=%0d leds=%h exp=%h rd=%h exp=%h",
                 i, bus_leds, exp_leds, dataRead, exp_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_reset();
    test_data_write();
    test_blink();
    test_pwm();
    test_ctrl();
    test_same_cycle();
    test_reset_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
